bin_to_seg4: RTL and testbench
==============================

# bin_to_seg4

Converts a 14-bit binary value (0..9999) into four 7-segment patterns for the 4-digit display multiplexer that consumes `seg1`..`seg4`. It runs an iterative double-dabble (shift-and-add-3) BCD conversion behind a load/busy/done handshake, then decodes each BCD digit to an active-low segment code. It sits directly upstream of the display multiplexer, and all four of its pattern outputs change together.

## Interface
- `BLANK_LZ`, default 1: when 1, leading-zero digits (thousands, hundreds, tens) are blanked; units are always shown.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `value` input 14: binary number to display; sampled only on an accepted load.
- `load` input 1: start-conversion request, sampled each rising edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: single-cycle pulse when `seg1`..`seg4` update.
- `seg1` output 7: units-digit pattern.
- `seg2` output 7: tens-digit pattern.
- `seg3` output 7: hundreds-digit pattern.
- `seg4` output 7: thousands-digit pattern.

## Operation
- Segment encoding: bit0=a … bit6=g, active-low (0 = lit).
  - Digit codes 0..9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
  - Blank: 0x7F. Dash (g only): 0x3F.
- FSM states: IDLE, SHIFT, OUT.
- IDLE: `busy`=0.
  - If `load`=1, capture `value` into a 14-bit shift register.
  - Clear the 16-bit BCD accumulator.
  - Latch an overflow flag (`value` > 9999).
  - Load the step counter with 14, then go to SHIFT.
- SHIFT: one step per cycle.
  - First, for each BCD nibble ≥ 5, add 3 to it.
  - Then shift {BCD, binary} left by one.
  - Decrement the counter; after the 14th step go to OUT.
- OUT:
  - Register the four decoded patterns into `seg1`..`seg4` simultaneously.
  - Assert `done` for this cycle, then return to IDLE.
- Overflow: all four outputs become dash (0x3F), regardless of BCD result or `BLANK_LZ`.
- Leading-zero blanking (`BLANK_LZ`=1):
  - `seg4` is blank if thousands = 0.
  - `seg3` is blank if thousands and hundreds = 0.
  - `seg2` is blank if thousands, hundreds and tens = 0.
  - `seg1` is never blank.
- `load` while `busy`=1 (SHIFT or OUT) is ignored; nothing is queued.
- `seg1`..`seg4` hold their last value between conversions and never show intermediate BCD state.
- Widths: BCD nibbles are 4 bits; add-3 never overflows a nibble for inputs ≤ 16383, because correction happens before the shift.

## Timing
- Reset values: `busy`=0, `done`=0, `seg1`..`seg4`=0x7F (blank), FSM=IDLE, internal registers 0.
- Load accepted at edge E0 → `busy`=1 from E0 until E15.
- Shift steps occur at edges E1..E14.
- At E15: outputs are updated, `done`=1 for the cycle following E15, and `busy`=0 from E15.
- Latency: 15 clocks from the load edge to valid patterns.
- Back-to-back: a `load` held high through E15 is accepted on the first edge where the FSM is in IDLE, i.e. E16 (`done` and `busy`=0 visible before it). Minimum period: 16 clocks per conversion.
- Reset asserted mid-conversion: all outputs return to reset values immediately (asynchronously); no `done` is produced for the aborted conversion.
- `value` may change freely except on the accepting edge.

## Test plan
- Reset, then load 1234 with `BLANK_LZ`=1 → `done` 15 clocks after load; seg4/3/2/1 = 0x79/0x24/0x30/0x19; `busy` high for exactly 15 cycles.
- Load 7 with `BLANK_LZ`=1 → seg4/3/2 = 0x7F, seg1 = 0x78. Repeat with `BLANK_LZ`=0 → seg4/3/2 = 0x40, seg1 = 0x78. Load 0 with `BLANK_LZ`=1 → seg1 = 0x40, others 0x7F.
- Load 9999 → all four outputs 0x10. Load 10000 and 16383 → all four outputs 0x3F, same 15-cycle latency.
- Load 1234, pulse `load` with `value`=5678 at cycle 5 → the second load is ignored; result is 1234 with a single `done`. Hold `load` high continuously → new conversion starts every 16 clocks.
- Load 4321, assert `rst_n`=0 at cycle 8 → outputs immediately 0x7F, `busy`=0, no `done`; after release, load 50 → seg2/seg1 = 0x12/0x40, seg4/seg3 blank.
- Randomised sweep 0..16383 against a reference model: each conversion takes exactly 15 clocks; outputs are stable (unchanged) between `done` pulses.

Source files
------------

// File: rtl/bin_to_seg4.sv
// bin_to_seg4: 14-bit binary to four active-low 7-segment digit patterns.
// Ports: clk, rst_n, value/load in; busy, done, seg1 (units)..seg4 (thousands) out.
module bin_to_seg4 #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4
);

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT
  } state_t;

  state_t      state;
  logic [13:0] sr;
  logic [15:0] bcd;
  logic [3:0]  cnt;
  logic        ovf;

  logic [15:0] bcd_adj;
  logic [6:0]  p1, p2, p3, p4;

  function automatic logic [3:0] adj3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = {adj3(bcd[15:12]), adj3(bcd[11:8]),
               adj3(bcd[7:4]),   adj3(bcd[3:0])};
  end

  always_comb begin
    p1 = dec(bcd[3:0]);
    p2 = dec(bcd[7:4]);
    p3 = dec(bcd[11:8]);
    p4 = dec(bcd[15:12]);
    if (BLANK_LZ) begin
      if (bcd[15:12] == 4'd0)
        p4 = BLANK;
      if (bcd[15:8] == 8'd0)
        p3 = BLANK;
      if (bcd[15:4] == 12'd0)
        p2 = BLANK;
    end
    // Out-of-range input: BCD result is meaningless.
    if (ovf) begin
      p1 = DASH;
      p2 = DASH;
      p3 = DASH;
      p4 = DASH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      seg1  <= BLANK;
      seg2  <= BLANK;
      seg3  <= BLANK;
      seg4  <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            sr    <= value;
            bcd   <= '0;
            ovf   <= (value > 14'd9999);
            cnt   <= 4'd14;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct before shifting so no nibble ever exceeds 9.
          {bcd, sr} <= {bcd_adj, sr} << 1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= OUT;
        end
        OUT: begin
          seg1  <= p1;
          seg2  <= p2;
          seg3  <= p3;
          seg4  <= p4;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg4.sv
// tb_bin_to_seg4: directed checks of bin_to_seg4 with and without blanking.
// Two instances share stimulus; one blanks leading zeros, one does not.
module tb_bin_to_seg4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;

  logic        busy, done, busy0, done0;
  logic [6:0]  s1, s2, s3, s4;
  logic [6:0]  z1, z2, z3, z4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_seg4 #(.BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy), .done(done),
    .seg1(s1), .seg2(s2), .seg3(s3), .seg4(s4)
  );

  bin_to_seg4 #(.BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy0), .done(done0),
    .seg1(z1), .seg2(z2), .seg3(z3), .seg4(z4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // pos: 0 units .. 3 thousands
  function automatic logic [6:0] ref_seg(input int v, input int pos,
                                         input bit blz);
    int p10;
    p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    if (v > 9999) return 7'h3F;
    if (blz && pos > 0 && v < p10) return 7'h7F;
    return code((v / p10) % 10);
  endfunction

  task automatic chk_segs(input string tag, input int v);
    chk({tag, ".s1"}, int'(s1), int'(ref_seg(v, 0, 1'b1)));
    chk({tag, ".s2"}, int'(s2), int'(ref_seg(v, 1, 1'b1)));
    chk({tag, ".s3"}, int'(s3), int'(ref_seg(v, 2, 1'b1)));
    chk({tag, ".s4"}, int'(s4), int'(ref_seg(v, 3, 1'b1)));
    chk({tag, ".z1"}, int'(z1), int'(ref_seg(v, 0, 1'b0)));
    chk({tag, ".z2"}, int'(z2), int'(ref_seg(v, 1, 1'b0)));
    chk({tag, ".z3"}, int'(z3), int'(ref_seg(v, 2, 1'b0)));
    chk({tag, ".z4"}, int'(z4), int'(ref_seg(v, 3, 1'b0)));
  endtask

  // One conversion; lat = edges from load edge to done seen,
  // bc = sampled cycles with busy high, stable = segs held meanwhile.
  task automatic convert(input int v, output int lat, output int bc,
                         output bit stable);
    logic [27:0] snap;
    @(negedge clk);
    value = v[13:0];
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load   = 1'b0;
    snap   = {s4, s3, s2, s1};
    lat    = 0;
    bc     = busy ? 1 : 0;
    stable = 1'b1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (!done && {s4, s3, s2, s1} !== snap) stable = 1'b0;
    end
  endtask

  task automatic run(input string tag, input int v);
    int  lat, bc;
    bit  st;
    convert(v, lat, bc, st);
    chk({tag, ".lat"}, lat, 15);
    chk({tag, ".busy"}, bc, 15);
    chk({tag, ".stable"}, int'(st), 1);
    chk({tag, ".done0"}, int'(done0), 1);
    chk_segs(tag, v);
  endtask

  initial begin
    int k, dcnt, d1, d2;
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.segs", int'({s4, s3, s2, s1}), 28'hFFFFFFF);
    chk("rst.segs0", int'({z4, z3, z2, z1}), 28'hFFFFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    run("v1234", 1234);
    chk("v1234.s4lit", int'(s4), 7'h79);
    chk("v1234.s1lit", int'(s1), 7'h19);
    run("v7", 7);
    chk("v7.s2blank", int'(s2), 7'h7F);
    chk("v7.z2zero", int'(z2), 7'h40);
    run("v0", 0);
    chk("v0.s1zero", int'(s1), 7'h40);
    run("v9999", 9999);
    chk("v9999.s3", int'(s3), 7'h10);
    run("v10000", 10000);
    chk("v10000.s1", int'(s1), 7'h3F);
    run("v16383", 16383);
    chk("v16383.z4", int'(z4), 7'h3F);
    run("v1000", 1000);
    run("v90", 90);
    run("v305", 305);

    // Load while busy is ignored.
    @(negedge clk);
    value = 14'd1234;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    k = 0;
    dcnt = 0;
    d1 = -1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 5) begin value = 14'd5678; load = 1'b1; end
      if (k == 6) load = 1'b0;
      if (done) begin dcnt++; if (d1 < 0) d1 = k; end
    end
    chk("ign.dcnt", dcnt, 1);
    chk("ign.lat", d1, 15);
    chk_segs("ign", 1234);

    // Continuous load: conversions every 16 clocks.
    @(negedge clk);
    value = 14'd4567;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    d1 = -1;
    d2 = -1;
    while (k < 40 && d2 < 0) begin
      @(negedge clk);
      k++;
      if (done) begin
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
    end
    load = 1'b0;
    chk("b2b.first", d1, 15);
    chk("b2b.second", d2, 31);
    chk_segs("b2b", 4567);
    repeat (20) @(negedge clk);
    chk("b2b.idle", int'(busy), 0);

    // Reset mid-conversion.
    @(negedge clk);
    value = 14'd4321;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.done", int'(done), 0);
    chk("arst.segs", int'({s4, s3, s2, s1}), 28'hFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("arst.nodone", dcnt, 0);
    run("v50", 50);
    chk("v50.s2", int'(s2), 7'h12);
    chk("v50.s3", int'(s3), 7'h7F);

    // Random sweep against the reference model.
    for (int i = 0; i < 12; i++) begin
      run("rnd", int'($urandom_range(0, 16383)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
